seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 135 +++++++++++++
 tb/tb_seg7_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: watches a multiplexed 4-digit 7-segment display and
// rebuilds the four hex digits it shows into a 16-bit value.
module seg7_capture #(
  parameter int STABLE = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_i,
  input  logic [3:0]  an_i,
  input  logic [6:0]  seg_i,
  output logic [15:0] value_o,
  output logic        valid_o,
  output logic        frame_o,
  output logic        glyph_err_o,
  output logic        an_err_o
);

  localparam logic [3:0]  STB       = 4'(STABLE);
  localparam logic [10:0] IDLE_PAIR = {4'hF, 7'h7F};

  logic [10:0] pair, pair_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] shadow, shadow_nxt, value_nxt;
  logic [3:0]  seen, seen_nxt;
  logic        valid_nxt, frame_nxt, gerr_nxt, aerr_nxt;
  logic        accept, same, gvalid, one_low;
  logic [3:0]  nib;
  logic [1:0]  k;

  always_comb begin
    gvalid = 1'b1;
    nib    = 4'h0;
    unique case (seg_i)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: gvalid = 1'b0;
    endcase
  end

  always_comb begin
    one_low = 1'b1;
    k       = 2'd0;
    unique case (an_i)
      4'b1110: k = 2'd0;
      4'b1101: k = 2'd1;
      4'b1011: k = 2'd2;
      4'b0111: k = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // A run of identical samples accepts once, when the count reaches STB
  always_comb begin
    same     = ({an_i, seg_i} == pair);
    pair_nxt = pair;
    cnt_nxt  = cnt;
    accept   = 1'b0;
    if (sample_i) begin
      if (!same) begin
        pair_nxt = {an_i, seg_i};
        cnt_nxt  = 4'd1;
        accept   = (STB == 4'd1);
      end else if (cnt != STB) begin
        cnt_nxt = cnt + 4'd1;
        accept  = (cnt + 4'd1 == STB);
      end
    end
  end

  always_comb begin
    shadow_nxt = shadow;
    seen_nxt   = seen;
    value_nxt  = value_o;
    valid_nxt  = valid_o;
    frame_nxt  = 1'b0;
    gerr_nxt   = 1'b0;
    aerr_nxt   = 1'b0;
    if (accept) begin
      if (one_low && gvalid) begin
        shadow_nxt[{k, 2'b00} +: 4] = nib;
        seen_nxt[k] = 1'b1;
        if (seen_nxt == 4'hF) begin
          value_nxt = shadow_nxt;
          valid_nxt = 1'b1;
          seen_nxt  = 4'h0;
          frame_nxt = 1'b1;
        end
      end else if (one_low) begin
        gerr_nxt    = 1'b1;
        seen_nxt[k] = 1'b0;
      end else if (an_i != 4'hF) begin
        aerr_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pair        <= IDLE_PAIR;
      cnt         <= 4'd0;
      shadow      <= 16'h0;
      seen        <= 4'h0;
      value_o     <= 16'h0;
      valid_o     <= 1'b0;
      frame_o     <= 1'b0;
      glyph_err_o <= 1'b0;
      an_err_o    <= 1'b0;
    end else begin
      pair        <= pair_nxt;
      cnt         <= cnt_nxt;
      shadow      <= shadow_nxt;
      seen        <= seen_nxt;
      value_o     <= value_nxt;
      valid_o     <= valid_nxt;
      frame_o     <= frame_nxt;
      glyph_err_o <= gerr_nxt;
      an_err_o    <= aerr_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and random stimulus for seg7_capture,
// checked every cycle against a run-length/array model of the display.
module tb_seg7_capture;

  localparam int STABLE = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        sample_i = 1'b0;
  logic [3:0]  an_i = 4'hF;
  logic [6:0]  seg_i = 7'h7F;
  logic [15:0] value_o;
  logic        valid_o, frame_o, glyph_err_o, an_err_o;

  seg7_capture #(.STABLE(STABLE)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .sample_i(sample_i),
    .an_i(an_i),
    .seg_i(seg_i),
    .value_o(value_o),
    .valid_o(valid_o),
    .frame_o(frame_o),
    .glyph_err_o(glyph_err_o),
    .an_err_o(an_err_o)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 0;
  int          frames = 0, gerrs = 0, aerrs = 0;

  // model state
  int          run = 0;
  logic [10:0] last = 11'h7FF;
  logic [3:0]  sh [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  bit          seen [4] = '{0, 0, 0, 0};
  logic [15:0] m_value = 16'h0;
  bit          m_valid = 0, m_frame = 0, m_gerr = 0, m_aerr = 0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [3:0] an, input logic [6:0] seg);
    int zeros, k, idx;
    zeros = 0; k = 0; idx = -1;
    for (int i = 0; i < 4; i++)
      if (!an[i]) begin zeros++; k = i; end
    for (int g = 0; g < 16; g++)
      if (glyph[g] == seg) idx = g;
    if (zeros > 1) m_aerr = 1;
    else if (zeros == 1) begin
      if (idx < 0) begin
        m_gerr = 1;
        seen[k] = 0;
      end else begin
        sh[k] = 4'(idx);
        seen[k] = 1;
        if (seen[0] && seen[1] && seen[2] && seen[3]) begin
          m_value = {sh[3], sh[2], sh[1], sh[0]};
          m_valid = 1;
          m_frame = 1;
          for (int i = 0; i < 4; i++) seen[i] = 0;
        end
      end
    end
  endtask

  task automatic model_step(input bit r, input bit s, input logic [3:0] an,
                            input logic [6:0] seg);
    m_frame = 0; m_gerr = 0; m_aerr = 0;
    if (r) begin
      run = 0; last = 11'h7FF; m_value = 0; m_valid = 0;
      for (int i = 0; i < 4; i++) begin sh[i] = 0; seen[i] = 0; end
    end else if (s) begin
      if ({an, seg} == last) run++;
      else begin run = 1; last = {an, seg}; end
      if (run == STABLE) model_accept(an, seg);
    end
  endtask

  task automatic compare();
    chk("value", value_o, m_value);
    chk("valid", 16'(valid_o), 16'(m_valid));
    chk("frame", 16'(frame_o), 16'(m_frame));
    chk("glyph_err", 16'(glyph_err_o), 16'(m_gerr));
    chk("an_err", 16'(an_err_o), 16'(m_aerr));
    if (frame_o === 1'b1) frames++;
    if (glyph_err_o === 1'b1) gerrs++;
    if (an_err_o === 1'b1) aerrs++;
  endtask

  task automatic cyc(input bit r, input bit s, input logic [3:0] an,
                     input logic [6:0] seg);
    @(negedge clk);
    if (chk_en) compare();
    rst_i = r; sample_i = s; an_i = an; seg_i = seg;
    @(posedge clk);
    model_step(r, s, an, seg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'hF, 7'h7F);
  endtask

  task automatic reset();
    cyc(1, 1, 4'b1110, 7'h30);
    chk_en = 1;
    idle(1);
  endtask

  task automatic digit(input int k, input logic [6:0] seg, input int n);
    logic [3:0] an;
    an = 4'hF;
    an[k] = 1'b0;
    for (int i = 0; i < n; i++) cyc(0, 1, an, seg);
  endtask

  task automatic frame4(input int n);
    digit(0, 7'h30, n); digit(1, 7'h12, n);
    digit(2, 7'h46, n); digit(3, 7'h79, n);
  endtask

  int f0, g0, a0;

  initial begin
    reset();
    chk("rst_value", value_o, 16'h0);
    chk("rst_valid", 16'(valid_o), 16'h0);

    // single samples only: nothing accepted
    frame4(1);
    idle(2);
    chk("single_value", value_o, 16'h0);
    chk("single_valid", 16'(valid_o), 16'h0);

    // basic frame
    reset(); f0 = frames;
    frame4(2);
    idle(2);
    chk("frame_value", value_o, 16'h1C53);
    chk("frame_valid", 16'(valid_o), 16'h1);
    chk("frame_pulses", 16'(frames - f0), 16'h1);

    // two anodes low
    reset(); f0 = frames; a0 = aerrs;
    digit(0, 7'h30, 2);
    cyc(0, 1, 4'b1100, 7'h30); cyc(0, 1, 4'b1100, 7'h30);
    idle(2);
    chk("anerr_pulses", 16'(aerrs - a0), 16'h1);
    chk("anerr_noframe", 16'(frames - f0), 16'h0);
    digit(1, 7'h12, 2); digit(2, 7'h46, 2); digit(3, 7'h79, 2);
    idle(2);
    chk("anerr_seen_kept", 16'(frames - f0), 16'h1);
    chk("anerr_value", value_o, 16'h1C53);

    // invalid glyph on digit 2
    reset(); f0 = frames; g0 = gerrs;
    digit(0, 7'h30, 2); digit(1, 7'h12, 2); digit(2, 7'h7F, 2);
    digit(3, 7'h79, 2);
    idle(2);
    chk("glyph_pulses", 16'(gerrs - g0), 16'h1);
    chk("glyph_noframe", 16'(frames - f0), 16'h0);
    digit(2, 7'h00, 2);
    idle(2);
    chk("glyph_frame", 16'(frames - f0), 16'h1);
    chk("glyph_value", value_o, 16'h1853);

    // long holds accept once
    reset(); f0 = frames;
    digit(0, 7'h30, 10); digit(1, 7'h12, 2);
    digit(2, 7'h46, 2); digit(3, 7'h79, 10);
    idle(3);
    chk("hold_frames", 16'(frames - f0), 16'h1);
    chk("hold_value", value_o, 16'h1C53);

    // reset mid-frame drops partial digits
    reset(); f0 = frames;
    digit(0, 7'h30, 2); digit(1, 7'h12, 2); digit(2, 7'h46, 2);
    reset();
    digit(3, 7'h79, 2);
    idle(2);
    chk("midrst_frames", 16'(frames - f0), 16'h0);
    chk("midrst_value", value_o, 16'h0);
    chk("midrst_valid", 16'(valid_o), 16'h0);

    // random traffic
    for (int p = 0; p < 1500; p++) begin
      logic [3:0] an;
      logic [6:0] seg;
      int len, sel;
      sel = int'($urandom_range(0, 7));
      an = 4'hF;
      if (sel < 5) an[$urandom_range(0, 3)] = 1'b0;
      else if (sel == 6) an = 4'($urandom);
      seg = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)]
                                        : 7'($urandom);
      len = int'($urandom_range(1, 4));
      if ($urandom_range(0, 149) == 0) cyc(1, 1'($urandom), an, seg);
      for (int i = 0; i < len; i++)
        cyc(0, ($urandom_range(0, 3) != 0), an, seg);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
